// File: rtl/memory_access_stage.sv
// Pipeline MEM stage: one outstanding data-memory access over req/ack, store lane
// alignment, load extraction/extension. Optional MEM_MISALIGN_CHECK_EN enables misalignment trapping.
module memory_access_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [31:0] ex_target_pc,
  input  logic [31:0] ex_pc_plus_4,
  input  logic [8:0]  ex_control_word,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] mem_data_out,
  output logic [31:0] target_pc,
  output logic [31:0] pc_plus_4_mem,
  output logic [31:0] ALU_result_mem,
  output logic [8:0]  control_word_mem,
  output logic        mem_valid,
  output logic        mem_misalign
);

  // Handshake: a bundle transfers from execute on a rising edge where
  // ex_valid && ex_ready; ex_ready is high exactly while the FSM is IDLE.
  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t      state_q, state_d;

  logic [31:0] hold_addr_q, hold_wdata_q, hold_alu_q, hold_tpc_q, hold_pc4_q;
  logic [3:0]  hold_be_q;
  logic [1:0]  hold_off_q;
  logic [2:0]  hold_funct3_q;
  logic [8:0]  hold_cw_q;
  logic        hold_we_q, hold_load_q;

  logic [31:0] out_data_q, out_data_d, out_tpc_q, out_tpc_d;
  logic [31:0] out_pc4_q, out_pc4_d, out_alu_q, out_alu_d;
  logic [8:0]  out_cw_q, out_cw_d;
  logic        out_valid_q, out_valid_d, out_mis_q, out_mis_d;

  logic        capture;
  logic        ex_mem_op, ex_misalign;
  logic [1:0]  ex_off, ex_size;
  logic [3:0]  ex_be;
  logic [31:0] ex_wdata, load_fmt;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ex_mem_op = ex_mem_read | ex_mem_write;
  assign ex_off    = ex_alu_result[1:0];
  assign ex_size   = ex_funct3[1:0];

`ifdef MEM_MISALIGN_CHECK_EN
  assign ex_misalign = ex_mem_op &
                       (((ex_size == 2'b01) & ex_off[0]) |
                        (ex_size[1] & (ex_off != 2'b00)));
`else
  assign ex_misalign = 1'b0;
`endif

  // Loads always fetch the full word; extraction happens on return.
  always_comb begin
    ex_be    = 4'b1111;
    ex_wdata = ex_store_data;
    if (!ex_mem_read) begin
      case (ex_size)
        2'b00:   ex_be = 4'b0001 << ex_off;
        2'b01:   ex_be = ex_off[1] ? 4'b1100 : 4'b0011;
        default: ex_be = 4'b1111;
      endcase
    end
    case (ex_size)
      2'b00:   ex_wdata = {4{ex_store_data[7:0]}};
      2'b01:   ex_wdata = {2{ex_store_data[15:0]}};
      default: ex_wdata = ex_store_data;
    endcase
  end

  always_comb begin
    ld_byte = dmem_rdata[7:0];
    case (hold_off_q)
      2'b00:   ld_byte = dmem_rdata[7:0];
      2'b01:   ld_byte = dmem_rdata[15:8];
      2'b10:   ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    ld_half = hold_off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (hold_funct3_q)
      3'b000:  load_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  load_fmt = {{16{ld_half[15]}}, ld_half};
      3'b100:  load_fmt = {24'd0, ld_byte};
      3'b101:  load_fmt = {16'd0, ld_half};
      default: load_fmt = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    capture     = 1'b0;
    out_valid_d = 1'b0;
    out_mis_d   = 1'b0;
    out_data_d  = 32'd0;
    out_tpc_d   = 32'd0;
    out_pc4_d   = 32'd0;
    out_alu_d   = 32'd0;
    out_cw_d    = 9'd0;
    case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (ex_mem_op && !ex_misalign) begin
            state_d = ACCESS;
            capture = 1'b1;
          end else begin
            // Non-memory ops and trapped misaligned accesses retire next cycle.
            out_valid_d = 1'b1;
            out_mis_d   = ex_misalign;
            out_tpc_d   = ex_target_pc;
            out_pc4_d   = ex_pc_plus_4;
            out_alu_d   = ex_alu_result;
            out_cw_d    = ex_misalign ? {1'b0, ex_control_word[7:0]} : ex_control_word;
          end
        end
      end
      ACCESS: begin
        if (dmem_ack) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
          out_data_d  = hold_load_q ? load_fmt : 32'd0;
          out_tpc_d   = hold_tpc_q;
          out_pc4_d   = hold_pc4_q;
          out_alu_d   = hold_alu_q;
          out_cw_d    = hold_cw_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      hold_addr_q   <= 32'd0;
      hold_wdata_q  <= 32'd0;
      hold_alu_q    <= 32'd0;
      hold_tpc_q    <= 32'd0;
      hold_pc4_q    <= 32'd0;
      hold_be_q     <= 4'd0;
      hold_off_q    <= 2'd0;
      hold_funct3_q <= 3'd0;
      hold_cw_q     <= 9'd0;
      hold_we_q     <= 1'b0;
      hold_load_q   <= 1'b0;
      out_data_q    <= 32'd0;
      out_tpc_q     <= 32'd0;
      out_pc4_q     <= 32'd0;
      out_alu_q     <= 32'd0;
      out_cw_q      <= 9'd0;
      out_valid_q   <= 1'b0;
      out_mis_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_tpc_q   <= out_tpc_d;
      out_pc4_q   <= out_pc4_d;
      out_alu_q   <= out_alu_d;
      out_cw_q    <= out_cw_d;
      out_valid_q <= out_valid_d;
      out_mis_q   <= out_mis_d;
      if (capture) begin
        hold_addr_q   <= {ex_alu_result[31:2], 2'b00};
        hold_wdata_q  <= ex_wdata;
        hold_alu_q    <= ex_alu_result;
        hold_tpc_q    <= ex_target_pc;
        hold_pc4_q    <= ex_pc_plus_4;
        hold_be_q     <= ex_be;
        hold_off_q    <= ex_off;
        hold_funct3_q <= ex_funct3;
        hold_cw_q     <= ex_control_word;
        hold_we_q     <= ex_mem_write;
        hold_load_q   <= ex_mem_read;
      end
    end
  end

  assign ex_ready   = (state_q == IDLE);
  assign dmem_req   = (state_q == ACCESS);
  assign dmem_we    = (state_q == ACCESS) & hold_we_q;
  assign dmem_be    = (state_q == ACCESS) ? hold_be_q : 4'd0;
  assign dmem_addr  = hold_addr_q;
  assign dmem_wdata = hold_wdata_q;

  assign mem_data_out     = out_data_q;
  assign target_pc        = out_tpc_q;
  assign pc_plus_4_mem    = out_pc4_q;
  assign ALU_result_mem   = out_alu_q;
  assign control_word_mem = out_cw_q;
  assign mem_valid        = out_valid_q;
`ifdef MEM_MISALIGN_CHECK_EN
  assign mem_misalign     = out_mis_q;
`else
  assign mem_misalign     = 1'b0;
`endif

endmodule
